// File: rtl/ball_track_filter_if.sv
// ball_track_filter_if: frame-sample inputs and smoothed-track outputs of the ball tracker.
interface ball_track_filter_if;
    logic        iEnable;
    logic        iVgaVRequest;
    logic [15:0] iCenterCol;
    logic [15:0] iCenterRow;
    logic [15:0] oCol;
    logic [15:0] oRow;
    logic [15:0] oVelCol;
    logic [15:0] oVelRow;
    logic        oLocked;
    logic        oFrameDone;
    modport master (
        output iEnable, iVgaVRequest, iCenterCol, iCenterRow,
        input  oCol, oRow, oVelCol, oVelRow, oLocked, oFrameDone
    );
    modport slave (
        input  iEnable, iVgaVRequest, iCenterCol, iCenterRow,
        output oCol, oRow, oVelCol, oVelRow, oLocked, oFrameDone
    );
endinterface

// File: rtl/ball_track_filter.sv
// ball_track_filter: per-frame centroid gating, lock acquisition and EMA smoothing.
module ball_track_filter #(
    parameter int H_MAX       = 640,
    parameter int V_MAX       = 480,
    parameter int SHIFT       = 2,
    parameter int LOCK_FRAMES = 3,
    parameter int LOST_FRAMES = 8,
    parameter int JUMP_LIMIT  = 64
) (
    input logic              iVgaClk,
    input logic              reset,
    ball_track_filter_if.slave trk
);
    localparam int AW = 16 + SHIFT;
    typedef enum logic {SEARCH, TRACK} state_t;
    state_t        r_state;
    logic          r_vreq_d, r_p1, r_valid, r_done, r_locked;
    logic [15:0]   r_smp_col, r_smp_row, r_ref_col, r_ref_row;
    logic [15:0]   r_col, r_row, r_vel_col, r_vel_row;
    logic [AW-1:0] r_acc_col, r_acc_row;
    logic [3:0]    r_lock_cnt, r_miss;
    logic          w_fe, w_accept;
    logic [15:0]   w_ref_col, w_ref_row, w_new_col, w_new_row;
    logic [16:0]   w_dc, w_dr, w_adc, w_adr;
    logic [AW-1:0] w_acc_col, w_acc_row;
    logic [3:0]    w_lock_nxt, w_miss_nxt;
    always_comb begin
        w_fe       = r_vreq_d & ~trk.iVgaVRequest & trk.iEnable;
        w_ref_col  = (r_state == TRACK) ? r_col : r_ref_col;
        w_ref_row  = (r_state == TRACK) ? r_row : r_ref_row;
        w_dc       = {1'b0, r_smp_col} - {1'b0, w_ref_col};
        w_dr       = {1'b0, r_smp_row} - {1'b0, w_ref_row};
        w_adc      = w_dc[16] ? -w_dc : w_dc;
        w_adr      = w_dr[16] ? -w_dr : w_dr;
        w_accept   = r_valid && (w_adc <= 17'(JUMP_LIMIT)) && (w_adr <= 17'(JUMP_LIMIT));
        w_acc_col  = r_acc_col + AW'(r_smp_col) - (r_acc_col >> SHIFT);
        w_acc_row  = r_acc_row + AW'(r_smp_row) - (r_acc_row >> SHIFT);
        w_new_col  = 16'(w_acc_col >> SHIFT);
        w_new_row  = 16'(w_acc_row >> SHIFT);
        w_lock_nxt = r_lock_cnt + 4'd1;
        w_miss_nxt = r_miss + 4'd1;
    end
    // r_p1 marks the gating/update cycle; outputs land one edge later with r_done
    always_ff @(posedge iVgaClk) begin
        if (!reset) begin
            r_state    <= SEARCH;
            r_vreq_d   <= 1'b0;
            r_p1       <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_smp_col  <= '0;
            r_smp_row  <= '0;
            r_ref_col  <= '0;
            r_ref_row  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_vel_col  <= '0;
            r_vel_row  <= '0;
            r_acc_col  <= '0;
            r_acc_row  <= '0;
            r_lock_cnt <= '0;
            r_miss     <= '0;
        end else begin
            r_vreq_d <= trk.iVgaVRequest;
            r_p1     <= w_fe;
            r_done   <= r_p1;
            if (w_fe) begin
                r_smp_col <= trk.iCenterCol;
                r_smp_row <= trk.iCenterRow;
                r_valid   <= (trk.iCenterCol < 16'(H_MAX)) && (trk.iCenterRow < 16'(V_MAX));
            end
            if (r_p1) begin
                if (r_state == SEARCH) begin
                    if (r_valid && (r_lock_cnt == 4'd0 || w_accept)) begin
                        r_ref_col <= r_smp_col;
                        r_ref_row <= r_smp_row;
                        if (w_lock_nxt == 4'(LOCK_FRAMES)) begin
                            r_state    <= TRACK;
                            r_locked   <= 1'b1;
                            r_acc_col  <= AW'(r_smp_col) << SHIFT;
                            r_acc_row  <= AW'(r_smp_row) << SHIFT;
                            r_col      <= r_smp_col;
                            r_row      <= r_smp_row;
                            r_vel_col  <= '0;
                            r_vel_row  <= '0;
                            r_miss     <= '0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= w_lock_nxt;
                        end
                    end else begin
                        r_lock_cnt <= '0;
                    end
                end else if (w_accept) begin
                    r_acc_col <= w_acc_col;
                    r_acc_row <= w_acc_row;
                    r_col     <= w_new_col;
                    r_row     <= w_new_row;
                    r_vel_col <= w_new_col - r_col;
                    r_vel_row <= w_new_row - r_row;
                    r_miss    <= '0;
                end else begin
                    r_vel_col <= '0;
                    r_vel_row <= '0;
                    if (w_miss_nxt == 4'(LOST_FRAMES)) begin
                        r_state    <= SEARCH;
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                        r_miss     <= '0;
                    end else begin
                        r_miss <= w_miss_nxt;
                    end
                end
            end
        end
    end
    assign trk.oCol       = r_col;
    assign trk.oRow       = r_row;
    assign trk.oVelCol    = r_vel_col;
    assign trk.oVelRow    = r_vel_row;
    assign trk.oLocked    = r_locked;
    assign trk.oFrameDone = r_done;
endmodule
